// File: rtl/key_debouncer_pkg.sv
// key_debouncer_pkg: shared FSM encodings for the key debouncer.
// Imported by the debouncer top.
package key_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    WAIT_PRESS   = 2'b01,
    PRESSED      = 2'b10,
    WAIT_RELEASE = 2'b11
  } state_e;

  localparam int unsigned KD_DEF_CYCLES = 4;

  // Level implied by a state: 1 while the key counts as pressed.
  function automatic logic level_of(state_e s);
    return (s == PRESSED) || (s == WAIT_RELEASE);
  endfunction

endpackage

// File: rtl/key_debouncer_if.sv
// key_debouncer_if: raw key input and debounced key outputs.
// master drives key_in; slave (debouncer) drives level/strobes.
interface key_debouncer_if;

  logic key_in;
  logic key_level;
  logic key_press;
  logic key_release;

  modport master (
    output key_in,
    input  key_level,
    input  key_press,
    input  key_release
  );

  modport slave (
    input  key_in,
    output key_level,
    output key_press,
    output key_release
  );

endinterface

// File: rtl/key_debouncer_sync_2ff.sv
// sync_2ff: two-flop synchronizer, sync active-high reset to 0.
// Ports: clk, rst, d_i (async level), q_o (synchronized level).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_debouncer.sv
// key_debouncer: sync + consecutive-sample filter for a push button.
// Ports: clk, rst, kif (key_in in; key_level/key_press/key_release out).
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = KD_DEF_CYCLES,
  parameter bit          INVERT          = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  key_debouncer_if.slave kif
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic s_q;

  // Polarity fixed before sync so the FSM always sees 1 = pressed.
  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (kif.key_in ^ INVERT),
    .q_o (s_q)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_of(state_q);
    press_d = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s_q) begin
          state_d = WAIT_PRESS;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_PRESS: begin
        if (!s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          level_d = 1'b1;
          press_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!s_q) begin
          state_d = WAIT_RELEASE;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_RELEASE: begin
        if (s_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          level_d = 1'b0;
          rel_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign kif.key_level   = level_q;
  assign kif.key_press   = press_q;
  assign kif.key_release = rel_q;

endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: directed checks of two debouncers (N=4).
// dut_a uses INVERT=0, dut_b uses INVERT=1; shared clk/rst.
module tb_key_debouncer;
  import key_debouncer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  key_debouncer_if kif_a ();
  key_debouncer_if kif_b ();

  key_debouncer #(
    .DEBOUNCE_CYCLES (4),
    .INVERT          (1'b0)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .kif (kif_a)
  );

  key_debouncer #(
    .DEBOUNCE_CYCLES (4),
    .INVERT          (1'b1)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .kif (kif_b)
  );

  always #5 clk = ~clk;

  // {level, press, release}
  function automatic logic [2:0] outs(bit b);
    if (b)
      return {kif_b.key_level, kif_b.key_press,
              kif_b.key_release};
    return {kif_a.key_level, kif_a.key_press,
            kif_a.key_release};
  endfunction

  task automatic chk(string tag, logic [2:0] obs,
                     logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Input already changed before the next edge E0.
  // Unchanged through E0+4, accepted at E0+5,
  // strobe gone at E0+6.
  task automatic accept(string tag, bit b, bit from_lvl);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk({tag, "_hold"}, outs(b), {from_lvl, 2'b00});
    end
    tick();
    chk({tag, "_edge"}, outs(b),
        from_lvl ? 3'b001 : 3'b110);
    tick();
    chk({tag, "_after"}, outs(b),
        from_lvl ? 3'b000 : 3'b100);
  endtask

  initial begin
    rst          = 1'b1;
    kif_a.key_in = 1'b1;
    kif_b.key_in = 1'b1;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_a", outs(1'b0), 3'b000);
      chk("rst_b", outs(1'b1), 3'b000);
    end

    rst = 1'b0;
    accept("rst_held", 1'b0, 1'b0);

    kif_a.key_in = 1'b0;
    tick();
    chk("glitch0", outs(1'b0), 3'b100);
    kif_a.key_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("glitch", outs(1'b0), 3'b100);
    end

    kif_a.key_in = 1'b0;
    accept("release", 1'b0, 1'b1);

    kif_a.key_in = 1'b1;
    accept("press", 1'b0, 1'b0);

    kif_a.key_in = 1'b0;
    accept("release2", 1'b0, 1'b1);

    kif_a.key_in = 1'b1;
    tick();
    chk("bounce0", outs(1'b0), 3'b000);
    tick();
    chk("bounce1", outs(1'b0), 3'b000);
    kif_a.key_in = 1'b0;
    tick();
    chk("bounce2", outs(1'b0), 3'b000);
    kif_a.key_in = 1'b1;
    accept("bounce", 1'b0, 1'b0);

    kif_a.key_in = 1'b0;
    accept("release3", 1'b0, 1'b1);

    kif_a.key_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midw", outs(1'b0), 3'b000);
    end
    chk("midw_cnt", {1'b0, dut_a.cnt_q}, 3'd2);
    chk("midw_st", {1'b0, dut_a.state_q},
        {1'b0, WAIT_PRESS});
    rst = 1'b1;
    tick();
    chk("midw_rst_st", {1'b0, dut_a.state_q},
        {1'b0, IDLE});
    chk("midw_rst_o", outs(1'b0), 3'b000);
    kif_a.key_in = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("midw_none", outs(1'b0), 3'b000);
    end

    chk("inv_idle", outs(1'b1), 3'b000);
    kif_b.key_in = 1'b0;
    accept("inv_press", 1'b1, 1'b0);
    kif_b.key_in = 1'b1;
    accept("inv_release", 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
